// File: rtl/instmem_loader_if.sv
// Control and byte-stream/write-port bundle for the instruction memory loader.
// slave = loader side, master = host/stream/memory side.
interface instmem_loader_if;
  logic        start;
  logic        sel_isr;
  logic [11:0] length;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic        wr_sel_isr;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;
  logic [2:0]  dbg_state;

  modport slave (
    input  start, sel_isr, length, abort, in_valid, in_data,
    output in_ready, wr_en, wr_sel_isr, wr_addr, wr_data,
    output busy, done, err, checksum, dbg_state
  );

  modport master (
    output start, sel_isr, length, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_sel_isr, wr_addr, wr_data,
    input  busy, done, err, checksum, dbg_state
  );
endinterface

// File: rtl/instmem_loader.sv
// Assembles a little-endian byte stream into halfwords and writes them into
// either the main instmem or the ISR ROM, with running checksum and abort.
module instmem_loader #(
  parameter int MEM_DEPTH = 2048,
  parameter int ISR_DEPTH = 2048
) (
  input  logic             clk,
  input  logic             nrst,
  instmem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [12:0] MEM_D = 13'(MEM_DEPTH);
  localparam logic [12:0] ISR_D = 13'(ISR_DEPTH);

  state_t      r_state;
  logic        r_sel;
  logic [11:0] r_len;
  logic [11:0] r_count;
  logic [10:0] r_addr;
  logic [15:0] r_data;
  logic [15:0] r_sum;
  logic        r_in_ready;
  logic        r_wr_en;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [12:0] w_depth;
  logic        w_len_bad;
  logic        w_xfer;
  logic        w_last;

  assign w_depth   = bus.sel_isr ? ISR_D : MEM_D;
  assign w_len_bad = {1'b0, bus.length} > w_depth;
  // Stream handshake: a byte moves on a rising edge where in_valid and
  // in_ready are both high; in_ready is high only while waiting for LO/HI.
  assign w_xfer    = bus.in_valid & r_in_ready;
  assign w_last    = (r_count + 12'd1) == r_len;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_len      <= 12'd0;
      r_count    <= 12'd0;
      r_addr     <= 11'd0;
      r_data     <= 16'd0;
      r_sum      <= 16'd0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sel   <= bus.sel_isr;
            r_len   <= bus.length;
            r_sum   <= 16'd0;
            r_count <= 12'd0;
            r_addr  <= 11'd0;
            r_busy  <= 1'b1;
            if (bus.length == 12'd0) begin
              r_state <= S_FIN;
              r_err   <= 1'b0;
              r_done  <= 1'b1;
            end else if (w_len_bad) begin
              r_state <= S_FIN;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_LO;
              r_err      <= 1'b0;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (bus.abort) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            r_data[7:0] <= bus.in_data;
            r_state     <= S_HI;
          end
        end
        S_HI: begin
          if (bus.abort) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            r_data[15:8] <= bus.in_data;
            r_state      <= S_WRITE;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b1;
          end
        end
        S_WRITE: begin
          // The strobe is already out this cycle, so the write is accounted
          // for even when abort arrives here.
          r_sum   <= r_sum + r_data;
          r_count <= r_count + 12'd1;
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else begin
            r_addr     <= r_addr + 11'd1;
            r_state    <= S_LO;
            r_in_ready <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_sel_isr = r_sel;
  assign bus.wr_addr    = r_addr;
  assign bus.wr_data    = r_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.checksum   = r_sum;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_instmem_loader.sv
// Randomized bench for instmem_loader: a transaction-level model turns each
// byte list into expected (sel, addr, halfword) writes and a checksum.
module tb_instmem_loader;

  localparam int MEM_DEPTH = 2048;
  localparam int ISR_DEPTH = 2048;

  logic clk;
  logic nrst;
  instmem_loader_if u_if ();

  instmem_loader #(.MEM_DEPTH(MEM_DEPTH), .ISR_DEPTH(ISR_DEPTH)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (u_if)
  );

  int total;
  int bad;
  int cyc;
  int wr_cnt;
  int done_cnt;
  int last_wr_cyc;
  int last_done_cyc;
  int start_cyc;
  logic [27:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [27:0] mon_e;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (u_if.wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("wr_in_ready", {31'd0, u_if.in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_item", {4'd0, u_if.wr_sel_isr, u_if.wr_addr, u_if.wr_data}, {4'd0, mon_e});
      end
    end
    if (u_if.done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      check("done_in_ready", {31'd0, u_if.in_ready}, 32'd0);
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic do_start(input logic sel, input logic [11:0] len, input logic with_abort);
    u_if.start   = 1'b1;
    u_if.sel_isr = sel;
    u_if.length  = len;
    u_if.abort   = with_abort;
    start_cyc    = cyc + 1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, gap)) @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = b;
    for (int k = 0; k < 50; k++) begin
      if (u_if.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'($urandom);
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // whole load: model, drive, then check completion results
  task automatic run_load(input logic sel, input logic [11:0] len, input int gap,
                          input logic with_abort, input logic busy_start);
    int depth;
    int n;
    int wr0;
    int d0;
    bit lbad;
    bit seen;
    logic [15:0] d;
    logic [15:0] sum;
    depth = sel ? ISR_DEPTH : MEM_DEPTH;
    lbad  = int'(len) > depth;
    n     = lbad ? 0 : int'(len);
    if (tx_q.size() != 2 * n) begin
      tx_q.delete();
      for (int i = 0; i < 2 * n; i++) tx_q.push_back(8'($urandom));
    end
    sum = 16'd0;
    for (int i = 0; i < n; i++) begin
      d = {tx_q[2*i+1], tx_q[2*i]};
      sum = sum + d;
      exp_q.push_back({sel, 11'(i), d});
    end
    wr0 = wr_cnt;
    d0  = done_cnt;
    do_start(sel, len, with_abort);
    if (busy_start) begin
      u_if.start   = 1'b1;
      u_if.sel_isr = ~sel;
      u_if.length  = 12'd7;
      @(negedge clk);
      u_if.start = 1'b0;
    end
    for (int i = 0; i < 2 * n; i++) send_byte(tx_q[i], gap);
    tx_q.delete();
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt > d0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("wr_count", 32'(wr_cnt - wr0), 32'(n));
    check("err", {31'd0, u_if.err}, {31'd0, lbad});
    check("checksum", {16'd0, u_if.checksum}, {16'd0, sum});
    if (n > 0) check("done_latency", 32'(last_done_cyc - last_wr_cyc), 32'd1);
    else       check("done_next_cycle", 32'(last_done_cyc - start_cyc), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("idle_busy", {31'd0, u_if.busy}, 32'd0);
    check("idle_done", {31'd0, u_if.done}, 32'd0);
  endtask

  initial begin
    int wr0;
    int d0;
    total = 0; bad = 0; cyc = 0; wr_cnt = 0; done_cnt = 0;
    last_wr_cyc = 0; last_done_cyc = 0; start_cyc = 0;
    nrst = 1'b0;
    u_if.start = 1'b0; u_if.sel_isr = 1'b0; u_if.length = 12'd0;
    u_if.abort = 1'b0; u_if.in_valid = 1'b0; u_if.in_data = 8'd0;
    #12;
    check("rst_in_ready", {31'd0, u_if.in_ready}, 32'd0);
    check("rst_wr_en",    {31'd0, u_if.wr_en}, 32'd0);
    check("rst_busy",     {31'd0, u_if.busy}, 32'd0);
    check("rst_done",     {31'd0, u_if.done}, 32'd0);
    check("rst_err",      {31'd0, u_if.err}, 32'd0);
    check("rst_addr_data_sum", {5'd0, u_if.wr_sel_isr, u_if.wr_addr, u_if.wr_data ^ u_if.checksum}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // basic little-endian load
    tx_q = '{8'h13, 8'h00, 8'hB7, 8'h02};
    run_load(1'b0, 12'd2, 0, 1'b0, 1'b0);
    check("basic_checksum_const", {16'd0, u_if.checksum}, 32'h0000_02CA);

    // same load under stream gaps
    tx_q = '{8'h13, 8'h00, 8'hB7, 8'h02};
    run_load(1'b0, 12'd2, 5, 1'b0, 1'b0);

    // randomized loads
    for (int t = 0; t < 6; t++)
      run_load(1'($urandom), 12'($urandom_range(1, 10)), $urandom_range(0, 3), 1'b0, 1'b0);

    // bounds
    run_load(1'b0, 12'd0, 0, 1'b0, 1'b0);
    run_load(1'b0, 12'd2049, 0, 1'b0, 1'b0);
    run_load(1'b1, 12'd2049, 0, 1'b0, 1'b0);
    run_load(1'b1, 12'd2048, 0, 1'b0, 1'b0);
    check("full_last_addr", {21'd0, u_if.wr_addr}, 32'h7FF);

    // abort while the second halfword's high byte is pending
    tx_q = '{8'hA1, 8'h5C, 8'h3E};
    exp_q.push_back({1'b0, 11'd0, 16'h5CA1});
    wr0 = wr_cnt;
    d0  = done_cnt;
    do_start(1'b0, 12'd4, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(tx_q[i], 1);
    tx_q.delete();
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    @(negedge clk);
    check("abort_writes", 32'(wr_cnt - wr0), 32'd1);
    check("abort_err", {31'd0, u_if.err}, 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", {31'd0, u_if.busy}, 32'd0);
    check("abort_exp_q", 32'(exp_q.size()), 32'd0);
    do_start(1'b0, 12'd1, 1'b0);
    check("restart_clears_err", {31'd0, u_if.err}, 32'd0);
    u_if.abort = 1'b1;
    @(negedge clk);
    u_if.abort = 1'b0;
    @(negedge clk);

    // reset in HI
    wr0 = wr_cnt;
    do_start(1'b1, 12'd4, 1'b0);
    send_byte(8'h77, 0);
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_outs", {26'd0, u_if.in_ready, u_if.wr_en, u_if.wr_sel_isr,
                           u_if.busy, u_if.done, u_if.err}, 32'd0);
    check("mid_rst_addr", {21'd0, u_if.wr_addr}, 32'd0);
    check("mid_rst_data", {16'd0, u_if.wr_data}, 32'd0);
    check("mid_rst_sum",  {16'd0, u_if.checksum}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    u_if.in_valid = 1'b1;
    repeat (6) @(negedge clk);
    u_if.in_valid = 1'b0;
    check("post_rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    check("post_rst_idle", {31'd0, u_if.busy}, 32'd0);

    // start while busy is ignored; start+abort in IDLE starts normally
    run_load(1'b0, 12'd2, 1, 1'b0, 1'b1);
    run_load(1'b1, 12'd3, 2, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
